// File: rtl/rr_request_encoder_if.sv
// Request/grant bundle between the requesters and rr_request_encoder.
// Valid/ready semantics: Req[i] is a level request. Enable=1 means that
// {A,B,C} names the single current owner, and {A,B,C} is stable for as long
// as Enable is high. The owner ends its tenure by pulsing Done or by dropping
// Req[{A,B,C}]. The arbiter may also revoke the grant when the hold limit
// expires. No other handshake exists.
interface rr_request_encoder_if;
  logic [7:0] Req;
  logic       Done;
  logic       Enable;
  logic       A;
  logic       B;
  logic       C;
  logic [7:0] GrantCount;
  logic [1:0] state;       // debug view of the arbiter FSM

  modport master (
    output Req, Done,
    input  Enable, A, B, C, GrantCount, state
  );

  modport slave (
    input  Req, Done,
    output Enable, A, B, C, GrantCount, state
  );
endinterface

// File: rtl/rr_request_encoder.sv
// Eight-way round-robin arbiter. It produces a registered grant index
// {A,B,C} and a grant-valid Enable for a downstream 3-to-8 decoder.
// Each grant is bounded by HOLD_MAX cycles, and Enable stays low for at
// least two cycles between owners.
module rr_request_encoder #(
  parameter int HOLD_MAX = 15
) (
  input logic                Clock,
  input logic                Reset,
  rr_request_encoder_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [1:0] state;
  logic [2:0] ptr;
  logic [7:0] hold;
  logic [2:0] idx;
  logic       enable;
  logic [7:0] grant_count;

  logic [2:0] sel;
  logic [2:0] cand;
  logic       found;
  logic       release_now;

  // Rotating priority scan: the first set request at or after ptr wins.
  always_comb begin
    sel   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && bus.Req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Any release cause ends the grant. Several causes at once still give one release.
  always_comb begin
    release_now = bus.Done || !bus.Req[idx] || (hold == HOLD_LIM);
  end

  // FSM, pointer, hold timer and grant counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hold        <= 8'd0;
      idx         <= 3'd0;
      enable      <= 1'b0;
      grant_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx         <= sel;
            enable      <= 1'b1;
            hold        <= 8'd1;
            grant_count <= grant_count + 8'd1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            enable <= 1'b0;
            ptr    <= idx + 3'd1;
            state  <= GAP;
          end else begin
            hold <= hold + 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Enable     = enable;
  assign bus.A          = idx[2];
  assign bus.B          = idx[1];
  assign bus.C          = idx[0];
  assign bus.GrantCount = grant_count;
  assign bus.state      = state;

endmodule
